// File: rtl/hbm_write_arbiter.sv
// hbm_write_arbiter: round-robin front end that lets NUM_REQ requesters share
// one HBM write master. One (address, size) command is in flight at a time.
// Zero-size commands complete without ever starting the master.
module hbm_write_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int ADDR_WIDTH = 64,
    parameter int GID_WIDTH  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_size,
    output logic [NUM_REQ-1:0]            req_done,
    output logic                          wm_ctrl_start,
    output logic [ADDR_WIDTH-1:0]         wm_ctrl_addr_offset,
    output logic [ADDR_WIDTH-1:0]         wm_ctrl_xfer_size_in_bytes,
    input  logic                          wm_ctrl_done,
    output logic                          wm_data_en,
    output logic [GID_WIDTH-1:0]          grant_id,
    output logic                          busy,
    output logic [31:0]                   xfer_count
);

    // One extra bit so the rotated candidate index can exceed NUM_REQ-1 before wrapping.
    localparam int CW = GID_WIDTH + 1;
    localparam logic [NUM_REQ-1:0] ONE_HOT_0 = NUM_REQ'(1);

    typedef enum logic [2:0] {IDLE, START, BUSY, DONE, ZDONE} state_t;

    state_t                 state_reg;
    logic [GID_WIDTH-1:0]   rr_last_reg;
    logic [GID_WIDTH-1:0]   grant_reg;
    logic [ADDR_WIDTH-1:0]  addr_reg;
    logic [ADDR_WIDTH-1:0]  size_reg;
    logic                   start_reg;
    logic                   data_en_reg;
    logic                   busy_reg;
    logic [NUM_REQ-1:0]     done_reg;
    logic [31:0]            count_reg;

    logic [GID_WIDTH-1:0]   pick_next;
    logic                   found_next;
    logic                   accept;
    logic [ADDR_WIDTH-1:0]  addr_arr [NUM_REQ];
    logic [ADDR_WIDTH-1:0]  size_arr [NUM_REQ];

    assign accept = (state_reg == IDLE) && found_next;

    // Unpack the per-requester command fields and drive the one-hot ready.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_lane
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign size_arr[gi]  = req_size[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_ready[gi] = accept && (pick_next == GID_WIDTH'(gi));
        end
    endgenerate

    // Round-robin search starting just after the last owner; scanning from the
    // farthest candidate down lets the nearest valid requester win last.
    always_comb begin
        logic [CW-1:0] cand;
        pick_next  = '0;
        found_next = 1'b0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = {1'b0, rr_last_reg} + CW'(k);
            if (cand >= CW'(NUM_REQ)) begin
                cand = cand - CW'(NUM_REQ);
            end
            if (req_valid[cand[GID_WIDTH-1:0]]) begin
                pick_next  = cand[GID_WIDTH-1:0];
                found_next = 1'b1;
            end
        end
    end

    // Command FSM with all outputs registered alongside the state.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            state_reg   <= IDLE;
            rr_last_reg <= GID_WIDTH'(NUM_REQ - 1);
            grant_reg   <= '0;
            addr_reg    <= '0;
            size_reg    <= '0;
            start_reg   <= 1'b0;
            data_en_reg <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= '0;
            count_reg   <= '0;
        end else begin
            start_reg <= 1'b0;
            done_reg  <= '0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        addr_reg    <= addr_arr[pick_next];
                        size_reg    <= size_arr[pick_next];
                        grant_reg   <= pick_next;
                        rr_last_reg <= pick_next;
                        if (size_arr[pick_next] == '0) begin
                            // Zero-size: complete straight away, master untouched.
                            state_reg <= ZDONE;
                            busy_reg  <= 1'b0;
                            done_reg  <= ONE_HOT_0 << pick_next;
                            count_reg <= count_reg + 32'd1;
                        end else begin
                            state_reg <= START;
                            busy_reg  <= 1'b1;
                            start_reg <= 1'b1;
                        end
                    end
                end
                START: begin
                    state_reg   <= BUSY;
                    data_en_reg <= 1'b1;
                end
                BUSY: begin
                    if (wm_ctrl_done) begin
                        state_reg   <= DONE;
                        data_en_reg <= 1'b0;
                        busy_reg    <= 1'b0;
                        done_reg    <= ONE_HOT_0 << grant_reg;
                        count_reg   <= count_reg + 32'd1;
                    end
                end
                DONE, ZDONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign wm_ctrl_start              = start_reg;
    assign wm_ctrl_addr_offset        = addr_reg;
    assign wm_ctrl_xfer_size_in_bytes = size_reg;
    assign wm_data_en                 = data_en_reg;
    assign grant_id                   = grant_reg;
    assign busy                       = busy_reg;
    assign req_done                   = done_reg;
    assign xfer_count                 = count_reg;

endmodule

// File: tb/tb_hbm_write_arbiter.sv
// Bench for hbm_write_arbiter: a transaction-level reference model predicts
// acceptances, master starts and completions (with cycle stamps) into queues;
// an independent monitor compares them with what the DUT presents.
module tb_hbm_write_arbiter;

    localparam int N  = 4;
    localparam int AW = 64;
    localparam int GW = 2;

    logic              aclk = 1'b0;
    logic              areset;
    logic [N-1:0]      req_valid;
    logic [N-1:0]      req_ready;
    logic [N*AW-1:0]   req_addr;
    logic [N*AW-1:0]   req_size;
    logic [N-1:0]      req_done;
    logic              wm_ctrl_start;
    logic [AW-1:0]     wm_ctrl_addr_offset;
    logic [AW-1:0]     wm_ctrl_xfer_size_in_bytes;
    logic              wm_ctrl_done;
    logic              wm_data_en;
    logic [GW-1:0]     grant_id;
    logic              busy;
    logic [31:0]       xfer_count;

    hbm_write_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW)) dut (
        .aclk                       (aclk),
        .areset                     (areset),
        .req_valid                  (req_valid),
        .req_ready                  (req_ready),
        .req_addr                   (req_addr),
        .req_size                   (req_size),
        .req_done                   (req_done),
        .wm_ctrl_start              (wm_ctrl_start),
        .wm_ctrl_addr_offset        (wm_ctrl_addr_offset),
        .wm_ctrl_xfer_size_in_bytes (wm_ctrl_xfer_size_in_bytes),
        .wm_ctrl_done               (wm_ctrl_done),
        .wm_data_en                 (wm_data_en),
        .grant_id                   (grant_id),
        .busy                       (busy),
        .xfer_count                 (xfer_count)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        int          cyc;
        int          id;
        logic [63:0] addr;
        logic [63:0] size;
        logic [31:0] cnt;
    } ev_t;

    typedef struct {
        int          cyc;
        logic        busy;
        logic        den;
        int          grant;
        logic [31:0] cnt;
    } st_t;

    ev_t acc_q[$];
    ev_t start_q[$];
    ev_t done_q[$];
    st_t cyc_q[$];
    int  grant_log[$];

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int m_delay;
    bit spur_en;
    bit log_en;

    // Reference model state, kept at transaction level.
    bit          m_inflight;
    int          m_free_at;
    int          m_busy_from;
    int          m_rr;
    int          m_grant;
    logic [31:0] m_count;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) step();
    endtask

    always @(posedge aclk) cyc <= cyc + 1;

    // Reference model: sees this cycle's inputs and predicts events with cycle stamps.
    always @(negedge aclk) begin
        if (areset) begin
            m_inflight = 0;
            m_free_at  = 0;
            m_busy_from = 0;
            m_rr       = N - 1;
            m_grant    = 0;
            m_count    = 0;
            acc_q.delete();
            start_q.delete();
            done_q.delete();
            cyc_q.delete();
        end else begin
            st_t st;
            ev_t e;
            st.cyc   = cyc;
            st.busy  = m_inflight;
            st.den   = m_inflight && (cyc >= m_busy_from);
            st.grant = m_grant;
            st.cnt   = m_count;
            cyc_q.push_back(st);
            if (m_inflight) begin
                if (cyc >= m_busy_from && wm_ctrl_done) begin
                    e = '{cyc + 1, m_grant, 64'd0, 64'd0, m_count + 32'd1};
                    done_q.push_back(e);
                    m_count    = m_count + 32'd1;
                    m_inflight = 0;
                    m_free_at  = cyc + 2;
                end
            end else if (cyc >= m_free_at) begin
                int win;
                win = -1;
                for (int k = 1; k <= N; k++) begin
                    int idx;
                    idx = (m_rr + k) % N;
                    if (win < 0 && req_valid[idx]) win = idx;
                end
                if (win >= 0) begin
                    logic [63:0] a;
                    logic [63:0] s;
                    a = req_addr[win*AW +: AW];
                    s = req_size[win*AW +: AW];
                    e = '{cyc, win, a, s, 32'd0};
                    acc_q.push_back(e);
                    m_rr = win;
                    if (s == 64'd0) begin
                        e = '{cyc + 1, win, 64'd0, 64'd0, m_count + 32'd1};
                        done_q.push_back(e);
                        m_count   = m_count + 32'd1;
                        m_free_at = cyc + 2;
                    end else begin
                        e = '{cyc + 1, win, a, s, 32'd0};
                        start_q.push_back(e);
                        m_inflight  = 1;
                        m_busy_from = cyc + 2;
                        m_grant     = win;
                    end
                end
            end
        end
    end

    // Monitor: compares what the DUT presents against the predicted events.
    always begin
        @(negedge aclk);
        #1;
        if (!areset) begin
            if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
                st_t st;
                st = cyc_q.pop_front();
                chk("busy", {63'd0, busy}, {63'd0, st.busy});
                chk("wm_data_en", {63'd0, wm_data_en}, {63'd0, st.den});
                chk("xfer_count", {32'd0, xfer_count}, {32'd0, st.cnt});
                if (st.busy) chk("grant_id", {62'd0, grant_id}, 64'(st.grant));
            end
            if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
                ev_t e;
                e = acc_q.pop_front();
                chk("req_ready", {60'd0, req_ready}, 64'(1) << e.id);
                if (log_en) begin
                    for (int k = 0; k < N; k++) if (req_ready[k]) grant_log.push_back(k);
                end
            end else begin
                chk("req_ready_quiet", {60'd0, req_ready}, 64'd0);
            end
            if (start_q.size() > 0 && start_q[0].cyc == cyc) begin
                ev_t e;
                e = start_q.pop_front();
                chk("wm_ctrl_start", {63'd0, wm_ctrl_start}, 64'd1);
                chk("wm_ctrl_addr_offset", wm_ctrl_addr_offset, e.addr);
                chk("wm_ctrl_xfer_size", wm_ctrl_xfer_size_in_bytes, e.size);
                chk("start_grant_id", {62'd0, grant_id}, 64'(e.id));
            end else begin
                chk("wm_ctrl_start_quiet", {63'd0, wm_ctrl_start}, 64'd0);
            end
            if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
                ev_t e;
                e = done_q.pop_front();
                chk("req_done", {60'd0, req_done}, 64'(1) << e.id);
                chk("done_xfer_count", {32'd0, xfer_count}, {32'd0, e.cnt});
            end else begin
                chk("req_done_quiet", {60'd0, req_done}, 64'd0);
            end
        end
    end

    // Write-master emulator: answers each start after a delay, plus stray dones.
    initial begin
        bit pend;
        int cnt;
        pend = 0;
        cnt = 0;
        wm_ctrl_done = 1'b0;
        forever begin
            @(posedge aclk);
            #1;
            wm_ctrl_done = 1'b0;
            if (areset) begin
                pend = 0;
            end else if (pend) begin
                if (cnt == 0) begin
                    wm_ctrl_done = 1'b1;
                    pend = 0;
                end else begin
                    cnt--;
                end
            end else if (wm_ctrl_start) begin
                pend = 1;
                cnt = (m_delay < 0) ? int'($urandom_range(0, 7)) : m_delay;
                if (spur_en && $urandom_range(0, 2) == 0) wm_ctrl_done = 1'b1;
            end else if (spur_en && $urandom_range(0, 5) == 0) begin
                wm_ctrl_done = 1'b1;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_order[5];
        exp_order = '{0, 1, 2, 3, 0};
        areset    = 1'b1;
        req_valid = '0;
        req_addr  = '0;
        req_size  = '0;
        m_delay   = 4;
        spur_en   = 0;
        log_en    = 0;
        drain(3);

        chk("rst_req_ready", {60'd0, req_ready}, 64'd0);
        chk("rst_req_done", {60'd0, req_done}, 64'd0);
        chk("rst_start", {63'd0, wm_ctrl_start}, 64'd0);
        chk("rst_addr", wm_ctrl_addr_offset, 64'd0);
        chk("rst_size", wm_ctrl_xfer_size_in_bytes, 64'd0);
        chk("rst_data_en", {63'd0, wm_data_en}, 64'd0);
        chk("rst_grant", {62'd0, grant_id}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_count", {32'd0, xfer_count}, 64'd0);
        areset = 1'b0;

        // All requesters active, master answers 5 cycles after each start.
        for (int i = 0; i < N; i++) begin
            req_addr[i*AW +: AW] = 64'h1_0000 * (i + 1);
            req_size[i*AW +: AW] = 64'h40 * (i + 1);
        end
        grant_log.delete();
        log_en = 1;
        req_valid = '1;
        for (int i = 0; i < 200 && grant_log.size() < 5; i++) step();
        log_en = 0;
        req_valid = '0;
        for (int i = 0; i < 5; i++)
            chk($sformatf("fair_order%0d", i), 64'((i < grant_log.size()) ? grant_log[i] : 99), 64'(exp_order[i]));
        drain(20);

        // Single command on requester 2, master done 9 cycles after start.
        m_delay = 8;
        req_addr[2*AW +: AW] = 64'h1000;
        req_size[2*AW +: AW] = 64'h200;
        req_valid = 4'b0100;
        #1;
        chk("single_ready", {60'd0, req_ready}, 64'h4);
        step();
        req_valid = '0;
        chk("single_start", {63'd0, wm_ctrl_start}, 64'd1);
        chk("single_addr", wm_ctrl_addr_offset, 64'h1000);
        chk("single_size", wm_ctrl_xfer_size_in_bytes, 64'h200);
        drain(20);

        // Zero-size command on requester 1.
        req_size[1*AW +: AW] = 64'd0;
        req_valid = 4'b0010;
        #1;
        chk("zero_ready", {60'd0, req_ready}, 64'h2);
        step();
        req_valid = '0;
        chk("zero_done", {60'd0, req_done}, 64'h2);
        chk("zero_no_start", {63'd0, wm_ctrl_start}, 64'd0);
        drain(5);

        // Randomized traffic with stray master dones.
        spur_en = 1;
        m_delay = -1;
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N; i++) begin
                req_valid[i] = ($urandom_range(0, 1) == 1);
                req_addr[i*AW +: AW] = {$urandom, $urandom};
                req_size[i*AW +: AW] = ($urandom_range(0, 4) == 0) ? 64'd0 : {$urandom, $urandom | 32'd1};
            end
            step();
        end
        req_valid = '0;
        spur_en = 0;
        drain(20);

        // Asynchronous reset in the middle of BUSY.
        for (int i = 0; i < N; i++) req_size[i*AW +: AW] = 64'h100;
        m_delay = 30;
        req_valid = '1;
        for (int i = 0; i < 50 && !wm_data_en; i++) step();
        chk("reach_busy", {63'd0, wm_data_en}, 64'd1);
        #2;
        areset = 1'b1;
        #1;
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_data_en", {63'd0, wm_data_en}, 64'd0);
        chk("arst_req_done", {60'd0, req_done}, 64'd0);
        chk("arst_count", {32'd0, xfer_count}, 64'd0);
        drain(2);
        areset = 1'b0;
        m_delay = 3;
        grant_log.delete();
        log_en = 1;
        for (int i = 0; i < 20 && grant_log.size() < 1; i++) step();
        chk("post_reset_first", 64'((grant_log.size() > 0) ? grant_log[0] : 99), 64'd0);
        req_valid = '0;
        log_en = 0;
        drain(20);

        // Requester 3 holds valid; requester 0 joins during its BUSY.
        grant_log.delete();
        log_en = 1;
        req_valid = 4'b1000;
        for (int i = 0; i < 20 && !busy; i++) step();
        step();
        req_valid = 4'b1001;
        for (int i = 0; i < 40 && grant_log.size() < 2; i++) step();
        chk("b2b_first", 64'((grant_log.size() > 0) ? grant_log[0] : 99), 64'd3);
        chk("b2b_second", 64'((grant_log.size() > 1) ? grant_log[1] : 99), 64'd0);
        req_valid = '0;
        log_en = 0;
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
